// File: rtl/bank_ram_arbiter_pkg.sv
// Shared types and helpers for the bank RAM arbiter.
package bank_arb_pkg;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Requester id width that stays at least 1 bit for a single requester.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit at or above ptr, else lowest set bit.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic hit_hi;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        hit_hi = 1'b0;
        // Descending scans leave the lowest qualifying index as the winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vec[i] && (i >= int'(ptr))) begin
                hit_hi = 1'b1;
                gnt    = '0;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        if (!hit_hi) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_vec[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                    gnt_id = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bank_ram_arbiter.sv
// Round-robin arbiter sharing one single-port bank RAM, with bounded lock bursts.
//   state      | meaning
//   ARB_OPEN   | round-robin grant among all valid requesters
//   ARB_LOCKED | bank held by lock_owner until it drops lock or lock_cnt hits LOCK_MAX
module bank_ram_arbiter
    import bank_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LOCK_MAX   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] pick_gnt, gnt;
    logic [ID_W-1:0]    pick_id, gnt_id;
    logic               force_rel, xfer;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req_vec (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_id  (pick_id)
    );

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        gnt       = '0;
        gnt_id    = pick_id;
        force_rel = (state_q == ARB_LOCKED) && (lock_cnt_q == CNT_W'(LOCK_MAX));
        if (state_q == ARB_OPEN) begin
            gnt = pick_gnt;
        end else if (!force_rel && req_valid[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
        end
        if (rst) gnt = '0;
    end

    assign xfer      = |gnt;
    assign req_ready = gnt;
    assign ram_en    = xfer;
    assign ram_we    = xfer & req_we[gnt_id];
    assign ram_addr  = xfer ? req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_wdata = xfer ? req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_rdata;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lock_cnt_d  = lock_cnt_q;
        rsp_valid_d = (xfer && !req_we[gnt_id]) ? gnt : '0;
        case (state_q)
            ARB_OPEN: begin
                if (xfer) begin
                    rr_ptr_d = next_id(gnt_id);
                    if (req_lock[gnt_id]) begin
                        state_d    = ARB_LOCKED;
                        owner_d    = gnt_id;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                if (lock_cnt_q != CNT_W'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + 1'b1;
                if (force_rel || (xfer && !req_lock[owner_q])) begin
                    state_d    = ARB_OPEN;
                    rr_ptr_d   = next_id(owner_q);
                    lock_cnt_d = '0;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_OPEN;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_bank_ram_arbiter.sv
// Directed bench for bank_ram_arbiter with a behavioural 1-cycle-read RAM.
module tb_bank_ram_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0, req_we = '0, req_lock = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]  req_ready, rsp_valid;
    logic [DW-1:0]  rsp_rdata, ram_wdata;
    logic [DW-1:0]  ram_rdata = '0;
    logic           ram_en, ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_lock[i]  = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b exp 0", ram_en); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0000", rsp_valid); end
        clear_reqs(); rst = 1'b0;
        #1;
        checks++; if (ram_addr !== '0 || ram_we !== 1'b0) begin errors++; $display("FAIL idle_ram got addr %h we %b exp 0 0", ram_addr, ram_we); end
    endtask

    task automatic test_single_read();
        @(negedge clk); set_req(0, 1, 1, 0, 10'h005, 64'hDEAD_BEEF);
        #1;
        checks++; if (req_ready !== 4'b0001 || ram_we !== 1'b1 || ram_wdata !== 64'hDEAD_BEEF)
            begin errors++; $display("FAIL sr_write got rdy %b we %b wd %h exp 0001 1 deadbeef", req_ready, ram_we, ram_wdata); end
        @(negedge clk); set_req(0, 1, 0, 0, 10'h005, '0);
        #1;
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h005)
            begin errors++; $display("FAIL sr_read got en %b we %b addr %h exp 1 0 005", ram_en, ram_we, ram_addr); end
        @(negedge clk); clear_reqs();
        checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 64'hDEAD_BEEF)
            begin errors++; $display("FAIL sr_rsp got %b %h exp 0001 deadbeef", rsp_valid, rsp_rdata); end
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL sr_rsp_clear got %b exp 0000", rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp_g, exp_r;
        do_reset();
        exp_r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < NR; i++) set_req(i, 1, 0, 0, AW'(8'h40 + i), '0);
            exp_g = NR'(1) << (k % NR);
            #1;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant k=%0d got %b exp %b", k, req_ready, exp_g); end
            checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL fair_rsp k=%0d got %b exp %b", k, rsp_valid, exp_r); end
            exp_r = exp_g;
        end
        @(negedge clk); clear_reqs();
        checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL fair_last_rsp got %b exp 1000", rsp_valid); end
    endtask

    task automatic test_lock_burst();
        @(negedge clk); set_req(2, 1, 1, 1, 10'h020, 64'hA0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_c1 got %b exp 0100", req_ready); end
        @(negedge clk); set_req(2, 1, 1, 1, 10'h021, 64'hA1); set_req(0, 1, 0, 0, 10'h020, '0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_c2 got %b exp 0100", req_ready); end
        @(negedge clk); set_req(2, 1, 1, 0, 10'h022, 64'hA2);
        #1;
        checks++; if (req_ready !== 4'b0100 || ram_addr !== 10'h022)
            begin errors++; $display("FAIL lock_c3 got %b addr %h exp 0100 022", req_ready, ram_addr); end
        @(negedge clk); set_req(2, 0, 0, 0, '0, '0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_after got %b exp 0001", req_ready); end
        @(negedge clk); clear_reqs();
        checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 64'hA0)
            begin errors++; $display("FAIL lock_rsp got %b %h exp 0001 a0", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_forced_release();
        @(negedge clk); set_req(1, 1, 0, 1, 10'h021, '0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fr_lock got %b exp 0010", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); set_req(1, 0, 0, 1, '0, '0); set_req(0, 1, 0, 0, 10'h005, '0);
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL fr_hold k=%0d got %b exp 0000", k, req_ready); end
        end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fr_release got %b exp 0001", req_ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); clear_reqs(); set_req(2, 1, 0, 0, 10'h005, '0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant got %b exp 0100", req_ready); end
        @(negedge clk); clear_reqs(); rst = 1'b1; set_req(1, 1, 0, 0, 10'h005, '0); set_req(3, 1, 0, 0, 10'h005, '0);
        #1;
        checks++; if (rsp_valid !== 4'b0100 || req_ready !== 4'b0000 || ram_en !== 1'b0)
            begin errors++; $display("FAIL rm_during got rsp %b rdy %b en %b exp 0100 0000 0", rsp_valid, req_ready, ram_en); end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_drop got %b exp 0000", rsp_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_first got %b exp 0010", req_ready); end
        @(negedge clk); clear_reqs();
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 1, 1, 0, 10'h007, 64'h1234); set_req(1, 1, 0, 0, 10'h007, '0);
        #1;
        checks++; if (req_ready !== 4'b0001 || ram_we !== 1'b1) begin errors++; $display("FAIL ct_write got %b we %b exp 0001 1", req_ready, ram_we); end
        @(negedge clk); set_req(0, 0, 0, 0, '0, '0);
        #1;
        checks++; if (req_ready !== 4'b0010 || ram_we !== 1'b0) begin errors++; $display("FAIL ct_read got %b we %b exp 0010 0", req_ready, ram_we); end
        @(negedge clk); clear_reqs();
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 64'h1234)
            begin errors++; $display("FAIL ct_rsp got %b %h exp 0010 1234", rsp_valid, rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_lock_burst();
        test_forced_release();
        test_reset_mid();
        test_contention();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
